// File: rtl/uart_tx_port.sv
// 8N1 serial transmitter fed from a CPU output port through a small FIFO.
// Ports: clk, reset (async, low), dato/we/clr_ovf in; tx, estado, cnt out.
module uart_tx_port #(
    parameter int DIV   = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    dato,
    input  logic          we,
    input  logic          clr_ovf,
    output logic          tx,
    output logic [7:0]    estado,
    output logic [AW:0]   cnt
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
    localparam logic [AW:0]   FULLC = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] bitcnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          busy;
    logic          ovf;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic bit_end;

    assign full    = (cnt == FULLC);
    assign empty   = (cnt == '0);
    assign push    = we && !full;
    assign bit_end = (bitcnt == LAST);
    // Pop when idle, or on the final stop cycle so frames run back-to-back.
    assign pop     = !empty &&
                     ((state == IDLE) || ((state == STOP) && bit_end));

    assign estado = {4'b0000, ovf, busy, empty, full};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= dato;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
            // A dropped write outranks a clear in the same cycle.
            if (we && full) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            bitcnt <= '0;
            idx    <= '0;
            shift  <= '0;
            tx     <= 1'b1;
            busy   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        state  <= START;
                        shift  <= mem[rp];
                        bitcnt <= '0;
                        tx     <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state  <= DATA;
                        bitcnt <= '0;
                        idx    <= '0;
                        tx     <= shift[0];
                    end else begin
                        bitcnt <= bitcnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bitcnt <= '0;
                        if (idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            idx   <= idx + 3'd1;
                            shift <= {1'b0, shift[7:1]};
                            tx    <= shift[1];
                        end
                    end else begin
                        bitcnt <= bitcnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bitcnt <= '0;
                        if (pop) begin
                            state <= START;
                            shift <= mem[rp];
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bitcnt <= bitcnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
